// File: rtl/fifo_wr_arb_if.sv
// rtl/fifo_wr_arb_if.sv - requester/FIFO-write bundle shared by fifo_wr_arb and its users
//
// Signals
//   req_valid  NREQ        per-requester beat valid, held until req_ready
//   req_data   NREQ*DSIZE  requester i data at [i*DSIZE +: DSIZE]
//   req_last   NREQ        last beat of a packet
//   req_ready  NREQ        one-hot beat accept
//   wr_full    1           FIFO full flag (registered in the FIFO)
//   wr_inc     1           write strobe into the FIFO
//   wr_data    DSIZE       write data into the FIFO
//   gnt_valid  1           a grant is held
//   gnt_id     IDXW        index of the granted requester
// Modports
//   master  requester/FIFO side (drives requests and wr_full)
//   slave   arbiter side
interface fifo_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int IDXW  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wr_full;
    logic                  wr_inc;
    logic [DSIZE-1:0]      wr_data;
    logic                  gnt_valid;
    logic [IDXW-1:0]       gnt_id;

    modport master (
        output req_valid, req_data, req_last, wr_full,
        input  req_ready, wr_inc, wr_data, gnt_valid, gnt_id
    );

    modport slave (
        input  req_valid, req_data, req_last, wr_full,
        output req_ready, wr_inc, wr_data, gnt_valid, gnt_id
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin arbiter for the async FIFO write port
//
// Shares one FIFO write port among NREQ valid/ready requesters, at most one
// beat per wr_clk cycle, with a one-cycle grant latency out of IDLE.
// Optional macro FIFO_ARB_PKTLOCK_EN keeps a grant locked until the beat
// carrying req_last, so packets land contiguously in the FIFO.
//
// Ports
//   wr_clk  in  write-domain clock
//   wr_rst  in  synchronous active-high reset
//   arb     fifo_wr_arb_if.slave: req_valid/req_data/req_last/wr_full in,
//           req_ready/wr_inc/wr_data/gnt_valid/gnt_id out
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int IDXW  = 2
) (
    input  logic          wr_clk,
    input  logic          wr_rst,
    fifo_wr_arb_if.slave  arb
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [IDXW-1:0]   gnt_id, gnt_id_n;
    logic [IDXW-1:0]   rr_ptr, rr_ptr_n;
    logic [IDXW-1:0]   nxt_ptr;
    logic [IDXW:0]     pick;
    logic              beat;
    logic              release_c;

`ifdef FIFO_ARB_PKTLOCK_EN
    logic              lock, lock_n;
`else
    logic              unused_req_last;
    assign unused_req_last = ^arb.req_last;
`endif

    // First valid requester in rotation order start, start+1, ... mod NREQ.
    // MSB of the result flags that a winner exists.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IDXW-1:0] start);
        logic [IDXW:0]   r;
        logic [IDXW-1:0] idx;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDXW'((int'(start) + k) % NREQ);
            if (v[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    // Beat gated by reset so nothing is accepted in a reset cycle.
    assign beat = (state == BUSY) && arb.req_valid[gnt_id] && !arb.wr_full && !wr_rst;

    assign arb.wr_inc    = beat;
    assign arb.req_ready = beat ? (NREQ'(1) << gnt_id) : '0;
    assign arb.wr_data   = arb.req_data[int'(gnt_id) * DSIZE +: DSIZE];
    assign arb.gnt_valid = (state == BUSY);
    assign arb.gnt_id    = gnt_id;

    assign nxt_ptr = IDXW'((int'(gnt_id) + 1) % NREQ);

    always_comb begin
        state_n   = state;
        gnt_id_n  = gnt_id;
        rr_ptr_n  = rr_ptr;
        release_c = 1'b0;
        pick      = '0;
`ifdef FIFO_ARB_PKTLOCK_EN
        lock_n    = lock;
`endif
        case (state)
            IDLE: begin
                pick = rr_pick(arb.req_valid, rr_ptr);
                if (pick[IDXW]) begin
                    state_n  = BUSY;
                    gnt_id_n = pick[IDXW-1:0];
                end
            end
            BUSY: begin
                // A full FIFO freezes grant, lock and pointer.
                if (!arb.wr_full) begin
`ifdef FIFO_ARB_PKTLOCK_EN
                    if (beat) begin
                        release_c = arb.req_last[gnt_id];
                        lock_n    = !arb.req_last[gnt_id];
                    end else begin
                        release_c = !arb.req_valid[gnt_id] && !lock;
                    end
`else
                    // Not full: either a beat happened or the owner went idle.
                    release_c = 1'b1;
`endif
                    if (release_c) begin
                        rr_ptr_n = nxt_ptr;
                        // Current owner is searched last, so it keeps the port
                        // only when nobody else is asking.
                        pick = rr_pick(arb.req_valid, nxt_ptr);
                        if (pick[IDXW]) begin
                            gnt_id_n = pick[IDXW-1:0];
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state  <= IDLE;
            gnt_id <= '0;
            rr_ptr <= '0;
`ifdef FIFO_ARB_PKTLOCK_EN
            lock   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            gnt_id <= gnt_id_n;
            rr_ptr <= rr_ptr_n;
`ifdef FIFO_ARB_PKTLOCK_EN
            lock   <= lock_n;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - scoreboard bench for fifo_wr_arb
`timescale 1ns/1ps
module tb_fifo_wr_arb;
    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int IDXW  = 2;
`ifdef FIFO_ARB_PKTLOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b1;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE), .IDXW(IDXW)) ifc ();

    fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .IDXW(IDXW)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .arb    (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DSIZE:0]   src_q[NREQ][$];   // {last, data} still to be offered
    logic [DSIZE-1:0] exp_q[NREQ][$];   // scoreboard: data expected in FIFO order per requester
    int               beat_log[$];      // requester index of each observed write
    logic [NREQ-1:0]  acc_mask   = '0;
    logic [NREQ-1:0]  presenting = '0;
    int               bubble_pct = 0;
    int               full_pct   = 0;

    // Reference model: who owns the port, where the rotation resumes, lock.
    bit m_busy = 0;
    int m_gnt  = 0;
    int m_ptr  = 0;
    bit m_lock = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int next_in_rotation(input logic [NREQ-1:0] v, input int s);
        for (int k = 0; k < NREQ; k++)
            if (v[(s + k) % NREQ]) return (s + k) % NREQ;
        return -1;
    endfunction

    // Monitor: outputs are stable mid-cycle; inputs only change just after posedge.
    always @(negedge wr_clk) begin : mon
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp_rdy;
        bit beat, rel;
        int p;
        v       = ifc.req_valid;
        beat    = m_busy && v[m_gnt] && !ifc.wr_full && !wr_rst;
        exp_rdy = '0;
        if (beat) exp_rdy[m_gnt] = 1'b1;
        check("gnt_valid", ifc.gnt_valid, m_busy);
        if (m_busy) check("gnt_id", ifc.gnt_id, m_gnt);
        check("wr_inc", ifc.wr_inc, beat);
        check("req_ready", ifc.req_ready, exp_rdy);
        acc_mask = ifc.req_ready;
        if (beat) begin
            beat_log.push_back(m_gnt);
            if (exp_q[m_gnt].size() == 0) begin
                n_checks++;
                $display("FAIL wr_data: got beat from requester %0d, required none pending", m_gnt);
            end else begin
                check("wr_data", ifc.wr_data, exp_q[m_gnt].pop_front());
            end
        end
        if (wr_rst) begin
            m_busy = 0; m_gnt = 0; m_ptr = 0; m_lock = 0;
        end else if (!m_busy) begin
            p = next_in_rotation(v, m_ptr);
            if (p >= 0) begin m_busy = 1; m_gnt = p; end
        end else if (!ifc.wr_full) begin
            rel = beat ? (!LOCK || ifc.req_last[m_gnt]) : (!v[m_gnt] && !m_lock);
            if (LOCK && beat) m_lock = !ifc.req_last[m_gnt];
            if (rel) begin
                m_ptr = (m_gnt + 1) % NREQ;
                p = next_in_rotation(v, m_ptr);
                if (p >= 0) m_gnt = p;
                else m_busy = 0;
            end
        end
    end

    task automatic add_pkt(input int i, input int len, input bit each_last);
        logic [DSIZE-1:0] d;
        for (int k = 0; k < len; k++) begin
            d = DSIZE'($urandom);
            src_q[i].push_back({each_last || (k == len - 1), d});
            exp_q[i].push_back(d);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0]       vv, ll;
        logic [NREQ*DSIZE-1:0] dd;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                presenting[i] = 1'b0;
            end
            if (!presenting[i] && src_q[i].size() > 0 && $urandom_range(99) >= bubble_pct)
                presenting[i] = 1'b1;
            vv[i] = presenting[i];
            if (presenting[i]) begin
                dd[i*DSIZE +: DSIZE] = src_q[i][0][DSIZE-1:0];
                ll[i] = src_q[i][0][DSIZE];
            end else begin
                dd[i*DSIZE +: DSIZE] = DSIZE'($urandom);
                ll[i] = 1'($urandom_range(1));
            end
        end
        ifc.req_valid = vv;
        ifc.req_data  = dd;
        ifc.req_last  = ll;
        ifc.wr_full   = ($urandom_range(99) < full_pct);
    endtask

    task automatic reset_dut(input int cycles);
        wr_rst = 1'b1;
        for (int k = 0; k < cycles; k++) step();
        wr_rst = 1'b0;
        beat_log.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int c = 0;
        while (beat_log.size() < n && c < budget) begin step(); c++; end
        if (beat_log.size() < n) begin
            n_checks++;
            $display("FAIL %s: got %0d beats, required %0d within %0d cycles", name, beat_log.size(), n, budget);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += exp_q[i].size();
        return s;
    endfunction

    task automatic drain(input int budget, input string name);
        int c = 0;
        while (pending() != 0 && c < budget) begin step(); c++; end
        step(); step();
        check(name, pending(), 0);
    endtask

    function automatic int count_of(input int r);
        int n = 0;
        foreach (beat_log[k]) if (beat_log[k] == r) n++;
        return n;
    endfunction

    initial begin
        int exp_seq[8];
        ifc.req_valid = '0;
        ifc.req_data  = '0;
        ifc.req_last  = '0;
        ifc.wr_full   = 1'b0;

        // T1: reset held two cycles with all requesters valid.
        for (int i = 0; i < NREQ; i++) add_pkt(i, 2, 1'b1);
        wr_rst = 1'b1;
        step(); step();
        check("t1_gnt_valid", ifc.gnt_valid, 1'b0);
        check("t1_wr_inc", ifc.wr_inc, 1'b0);
        check("t1_req_ready", ifc.req_ready, 4'b0000);
        wr_rst = 1'b0;
        beat_log.delete();
        step();
        check("t1_first_gnt_id", ifc.gnt_id, 2'd0);
        check("t1_first_gnt_valid", ifc.gnt_valid, 1'b1);

        // T2: beat-level fairness, one write every cycle.
        for (int k = 0; k < 8; k++) begin
            check("t2_wr_inc", ifc.wr_inc, 1'b1);
            if (k < 7) step();
        end
        step();
        check("t2_beats", beat_log.size(), 8);
        for (int k = 0; k < 8 && k < beat_log.size(); k++) check("t2_order", beat_log[k], k % 4);

        // T3: stall on full while granted to requester 2.
        reset_dut(1);
        full_pct = 100;
        add_pkt(2, 1, 1'b1);
        step(); step();
        for (int k = 0; k < 3; k++) begin
            check("t3_hold_gnt", ifc.gnt_id, 2'd2);
            check("t3_no_inc", ifc.wr_inc, 1'b0);
            check("t3_no_ready", ifc.req_ready, 4'b0000);
            if (k < 2) step();
        end
        full_pct = 0;
        ifc.wr_full = 1'b0;
        #1;
        check("t3_resume_inc", ifc.wr_inc, 1'b1);
        check("t3_resume_ready", ifc.req_ready, 4'b0100);
        check("t3_resume_data", ifc.wr_data, src_q[2][0][DSIZE-1:0]);
        step();
        check("t3_beat_from_2", (beat_log.size() == 1) ? beat_log[0] : -1, 2);

        // T4: single active requester, back-to-back writes then idle.
        reset_dut(1);
        add_pkt(3, 3, 1'b1);
        step(); step();
        for (int k = 0; k < 3; k++) begin
            check("t4_gnt_id", ifc.gnt_id, 2'd3);
            check("t4_wr_inc", ifc.wr_inc, 1'b1);
            step();
        end
        step();
        check("t4_idle", ifc.gnt_valid, 1'b0);
        check("t4_beats", count_of(3), 3);

        // T5: 4-beat packet from 0 competing with single beats from 1.
        reset_dut(1);
        add_pkt(0, 4, 1'b0);
        add_pkt(1, 4, 1'b1);
        wait_beats(8, 40, "t5_wait");
        if (LOCK) exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
        else      exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
        for (int k = 0; k < 8 && k < beat_log.size(); k++) check("t5_order", beat_log[k], exp_seq[k]);
        step(); step();

        // T6: reset after two beats of a 4-beat packet; requester 0 wins first afterwards.
        reset_dut(1);
        add_pkt(0, 4, 1'b0);
        add_pkt(1, 2, 1'b1);
        for (int c = 0; c < 40 && count_of(0) < 2; c++) step();
        check("t6_two_beats_before_reset", count_of(0), 2);
        reset_dut(1);
        check("t6_idle_after_reset", ifc.gnt_valid, 1'b0);
        wait_beats(1, 20, "t6_wait");
        if (beat_log.size() > 0) check("t6_regrant_0", beat_log[0], 0);
        drain(100, "t6_drain");

        // Random traffic with bubbles, full stalls and occasional resets.
        bubble_pct = 30;
        full_pct   = 20;
        for (int c = 0; c < 2000; c++) begin
            int i;
            i = $urandom_range(NREQ - 1);
            if (src_q[i].size() < 3) add_pkt(i, $urandom_range(4, 1), 1'b0);
            step();
            wr_rst = ($urandom_range(299) == 0);
        end
        wr_rst     = 1'b0;
        bubble_pct = 0;
        full_pct   = 0;
        drain(500, "random_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
